// File: rtl/uart_word_transmitter.sv
// UART 8N1 transmitter for 32-bit words: 4 bytes MSB-byte first, each byte LSB-first.
// One word per valid/ready handshake; all outputs come straight from flops.
`timescale 1ns/1ps
module uart_word_transmitter #(
    parameter int FREQUENCY_IN_HZ = 80_000_000,
    parameter int BAUD            = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        io_tx,
    output logic        busy,
    output logic        word_done
);

    localparam int CLKS_PER_BIT = FREQUENCY_IN_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("uart_word_transmitter: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [1:0]       byte_cnt, byte_cnt_nx;
    logic [31:0]      shreg, shreg_nx;
    logic             tx_nx, ready_nx, busy_nx, done_nx;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    // The byte on the line is always the top of the shift register.
    assign cur_byte = shreg[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            io_tx      <= 1'b1;
            word_ready <= 1'b1;
            busy       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            baud_cnt   <= baud_cnt_nx;
            bit_idx    <= bit_idx_nx;
            byte_cnt   <= byte_cnt_nx;
            shreg      <= shreg_nx;
            io_tx      <= tx_nx;
            word_ready <= ready_nx;
            busy       <= busy_nx;
            word_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_idx_nx  = bit_idx;
        byte_cnt_nx = byte_cnt;
        shreg_nx    = shreg;
        tx_nx       = io_tx;
        ready_nx    = word_ready;
        busy_nx     = busy;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                tx_nx       = 1'b1;
                ready_nx    = 1'b1;
                busy_nx     = 1'b0;
                baud_cnt_nx = '0;
                bit_idx_nx  = '0;
                byte_cnt_nx = '0;
                if (word_valid && word_ready) begin
                    shreg_nx = word_data;
                    state_nx = START;
                    tx_nx    = 1'b0;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_nx = '0;
                    bit_idx_nx  = '0;
                    state_nx    = DATA;
                    tx_nx       = cur_byte[0];
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nx = '0;
                        state_nx   = STOP;
                        tx_nx      = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_nx = '0;
                    if (byte_cnt != 2'd3) begin
                        // Next byte starts immediately, no idle gap inside a word.
                        byte_cnt_nx = byte_cnt + 2'd1;
                        shreg_nx    = {shreg[23:0], 8'h00};
                        state_nx    = START;
                        tx_nx       = 1'b0;
                    end else begin
                        byte_cnt_nx = '0;
                        state_nx    = IDLE;
                        done_nx     = 1'b1;
                        ready_nx    = 1'b1;
                        busy_nx     = 1'b0;
                        tx_nx       = 1'b1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Bench for uart_word_transmitter: a CLKS_PER_BIT=8 instance for most cases plus a
// default-parameter instance; line is checked cycle by cycle and decoded mid-bit.
`timescale 1ns/1ps
module tb_uart_word_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid8 = 1'b0, valid_d = 1'b0;
    logic [31:0] data8 = '0, data_d = '0;
    logic        ready8, tx8, busy8, done8;
    logic        ready_d, tx_d, busy_d, done_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_word_transmitter #(.FREQUENCY_IN_HZ(800), .BAUD(100)) dut (
        .clk(clk), .reset(rst), .word_valid(valid8), .word_data(data8),
        .word_ready(ready8), .io_tx(tx8), .busy(busy8), .word_done(done8)
    );

    uart_word_transmitter dut_def (
        .clk(clk), .reset(rst), .word_valid(valid_d), .word_data(data_d),
        .word_ready(ready_d), .io_tx(tx_d), .busy(busy_d), .word_done(done_d)
    );

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present a word and hold it until the handshake edge; returns 1ns after that edge.
    task automatic send_word(input bit d, input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        if (d) begin valid_d = 1'b1; data_d = w; end
        else   begin valid8  = 1'b1; data8  = w; end
        while (!(d ? ready_d : ready8) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n >= 2000), 32'd0);
        @(posedge clk); #1;
        if (d) valid_d = 1'b0; else valid8 = 1'b0;
    endtask

    // Checks 40*cpb frame cycles starting at the next negedge, then the word_done cycle.
    task automatic check_frame(input bit d, input int cpb, input logic [31:0] eb, input string nm);
        int wave_bad = 0;
        int hs_bad   = 0;
        int bitn, pos;
        logic [31:0] dec = '0;
        logic [7:0]  ebyte;
        logic        exp_bit, t, r, b, dn;
        for (int c = 0; c < 40 * cpb; c++) begin
            @(negedge clk);
            t = d ? tx_d : tx8;  r = d ? ready_d : ready8;
            b = d ? busy_d : busy8; dn = d ? done_d : done8;
            bitn    = c / cpb;
            pos     = bitn % 10;
            ebyte   = eb[31 - 8 * (bitn / 10) -: 8];
            exp_bit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : ebyte[pos - 1];
            if (t !== exp_bit) wave_bad++;
            if (r !== 1'b0 || b !== 1'b1 || dn !== 1'b0) hs_bad++;
            if ((c % cpb) == cpb / 2 && pos >= 1 && pos <= 8)
                dec[(3 - bitn / 10) * 8 + pos - 1] = t;
        end
        chk({nm, "_wave"}, wave_bad, 0);
        chk({nm, "_handshake"}, hs_bad, 0);
        chk({nm, "_decode"}, dec, eb);
        @(negedge clk);
        chk({nm, "_done"}, d ? {done_d, ready_d, busy_d, tx_d} : {done8, ready8, busy8, tx8}, 32'b1101);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;
        tbl[0] = '{32'h00400093, 8'h00, 8'h40, 8'h00, 8'h93};
        tbl[1] = '{32'h00800113, 8'h00, 8'h80, 8'h01, 8'h13};
        tbl[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};
        tbl[5] = '{32'h5A3C0FF0, 8'h5A, 8'h3C, 8'h0F, 8'hF0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", {tx8, ready8, busy8, done8}, 32'b1100);
        chk("reset_state_def", {tx_d, ready_d, busy_d, done_d}, 32'b1100);
        rst = 1'b0;

        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx8, ready8, busy8, done8} !== 4'b1100) idle_bad++;
            if ({tx_d, ready_d, busy_d, done_d} !== 4'b1100) idle_bad++;
        end
        chk("idle100", idle_bad, 0);

        // Table-driven single words
        for (int i = 0; i < 6; i++) begin
            send_word(1'b0, tbl[i].word);
            check_frame(1'b0, 8, {tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3}, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {done8, ready8, tx8}, 32'b011);
        end

        // Back-to-back: valid held high, next word already on the bus at word_done
        @(negedge clk);
        valid8 = 1'b1; data8 = 32'h00400093;
        @(posedge clk); #1;
        data8 = 32'h00800113;
        check_frame(1'b0, 8, 32'h00400093, "b2b_w0");
        @(posedge clk); #1;
        valid8 = 1'b0;
        check_frame(1'b0, 8, 32'h00800113, "b2b_w1");
        @(negedge clk);
        chk("b2b_idle", {done8, ready8, tx8}, 32'b011);

        // Data changes and valid pulses while busy are ignored
        send_word(1'b0, 32'h00400093);
        fork
            check_frame(1'b0, 8, 32'h00400093, "busy_ign");
            begin
                repeat (40) @(posedge clk); #1;
                data8 = 32'hFFFFFFFF; valid8 = 1'b1;
                repeat (5) @(posedge clk); #1;
                valid8 = 1'b0;
                repeat (100) @(posedge clk); #1;
                valid8 = 1'b1;
                @(posedge clk); #1;
                valid8 = 1'b0;
            end
        join
        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({tx8, ready8, busy8, done8} !== 4'b1100) idle_bad++;
        end
        chk("no_extra_word", idle_bad, 0);

        // Reset during data bits of byte 2 (all zero bits of 0x00400093)
        send_word(1'b0, 32'h00400093);
        repeat (180) @(negedge clk);
        chk("pre_rst_tx", tx8, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {tx8, ready8, busy8, done8}, 32'b1100);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({tx8, ready8, busy8, done8} !== 4'b1100) idle_bad++;
        end
        chk("rst_no_resume", idle_bad, 0);
        send_word(1'b0, 32'hA5A5A5A5);
        check_frame(1'b0, 8, 32'hA5A5A5A5, "after_rst");

        // Default parameters: 694 clocks per bit
        send_word(1'b1, 32'h12345678);
        check_frame(1'b1, 694, 32'h12345678, "default");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
